if_ctrl: RTL
============

Name: if_ctrl

Overview:
- Sequencer for the instruction-fetch (IF) stage; drives its control inputs S_MXPC, W_PC, read_file, write_file and WE.
- Loads instruction memory from file, runs sequential fetch with stall and branch-redirect handling, and halts on a HALT opcode.
- Dumps memory to file on request and gates host writes to instruction memory so they occur only while fetch is idle or halted.

Parameters:
- LOAD_CYCLES, 4: cycles read_file is held high during the initial memory load.
- DUMP_CYCLES, 4: cycles write_file is held high during a memory dump.
- BUBBLE_CYCLES, 1: fetch-invalid cycles after a branch redirect.
- HALT_OPCODE, 6'b111111: value of instruction[31:26] that halts fetch.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins load+run from IDLE.
- stall  in  1  downstream stall; freezes PC.
- branch_req  in  1  branch/jump resolved; take ALU target.
- dump_req  in  1  one-cycle pulse; request memory dump (HALT only).
- host_we  in  1  host instruction-memory write request.
- instruction  in  32  current word from IF stage.
- S_MXPC  out  1  PC mux select (0 = PC+4, 1 = dataALU).
- W_PC  out  1  PC write enable.
- read_file  out  1  load instruction memory from file.
- write_file  out  1  dump instruction memory to file.
- WE  out  1  instruction-memory write enable (gated host_we).
- fetch_valid  out  1  instruction output is valid this cycle.
- halted  out  1  block is in HALT.
- fetch_count  out  16  instructions issued since last start.

Behaviour:
- All outputs are registered.
- Reset (RST_N=0, any time including mid-load or mid-dump): state=IDLE, counters cleared, all outputs 0. It takes effect immediately, asynchronously.
- States: IDLE, LOAD, RUN, REDIRECT, HALT, DUMP.
- IDLE:
  - WE = host_we (one-cycle registered).
  - On start, go to LOAD; host_we is ignored that cycle and afterwards.
  - fetch_count clears on start.
- LOAD:
  - read_file=1 for exactly LOAD_CYCLES cycles (down-counter), then RUN.
  - W_PC=0 and fetch_valid=0 throughout.
  - start, stall, branch_req and dump_req are ignored.
- RUN: priority is branch_req > stall > halt detect > normal.
  - branch_req=1: next cycle S_MXPC=1, W_PC=1, fetch_valid=0; go to REDIRECT. Branch wins over a simultaneous stall. The HALT opcode present that cycle is ignored (flushed).
  - stall=1 (no branch): W_PC=0, S_MXPC=0, fetch_valid=1 (instruction held); fetch_count holds.
  - instruction[31:26]==HALT_OPCODE: W_PC=0, fetch_valid=0; go to HALT. The HALT word is not counted.
  - Otherwise: W_PC=1, S_MXPC=0, fetch_valid=1; fetch_count+1, wrapping at 16'hFFFF to 0.
- REDIRECT:
  - S_MXPC=0, W_PC=0, fetch_valid=0 for BUBBLE_CYCLES cycles, then RUN.
  - branch_req during REDIRECT restarts the bubble counter (one extra S_MXPC=1/W_PC=1 cycle).
  - stall does not extend the bubble.
- HALT:
  - halted=1, W_PC=0, fetch_valid=0; WE = host_we.
  - dump_req goes to DUMP.
  - start goes to LOAD (reload + restart). If start and dump_req arrive together, dump_req wins and start is dropped.
- DUMP:
  - write_file=1 for exactly DUMP_CYCLES cycles; WE forced 0; then IDLE.
  - halted=0 on exit.
- Only one of read_file, write_file or WE is ever 1 in a given cycle.
- host_we outside IDLE/HALT is dropped, not queued.

Test Plan:
- Reset, then start pulse at cycle 10, LOAD_CYCLES=4 -> read_file=1 for cycles 11-14; RUN from cycle 15 with W_PC=1, fetch_valid=1; fetch_count=3 after 3 non-halt fetches.
- In RUN, stall=1 for 3 cycles -> W_PC=0, fetch_valid=1, fetch_count constant; release -> W_PC=1 the next cycle.
- branch_req and stall asserted together -> one cycle with S_MXPC=1, W_PC=1, then 1 bubble (fetch_valid=0), then RUN. A HALT word presented in the same cycle does not halt.
- instruction=32'hFC000000 in RUN -> halted=1, W_PC=0; dump_req -> write_file=1 for 4 cycles, then IDLE with all outputs 0.
- host_we=1 in RUN -> WE=0; in IDLE or HALT -> WE=1 one cycle later; in DUMP -> WE=0.
- RST_N dropped mid-LOAD (cycle 2 of 4) -> read_file=0 immediately; after release, state is IDLE and start is required again.

Source files
------------

// File: rtl/if_ctrl.sv
// Instruction-fetch stage sequencer: loads instruction memory, runs
// sequential fetch with stall and branch-redirect handling, halts on the
// HALT opcode, dumps memory on request and gates host writes to memory.
// Every output is registered; the next-cycle value is built in one
// combinational block and captured together with the state.
module if_ctrl #(
  parameter int          LOAD_CYCLES   = 4,
  parameter int          DUMP_CYCLES   = 4,
  parameter int          BUBBLE_CYCLES = 1,
  parameter logic [5:0]  HALT_OPCODE   = 6'b111111
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_req,
  input  logic        dump_req,
  input  logic        host_we,
  input  logic [31:0] instruction,
  output logic        S_MXPC,
  output logic        W_PC,
  output logic        read_file,
  output logic        write_file,
  output logic        WE,
  output logic        fetch_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RUN      = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_HALT     = 3'd4,
    ST_DUMP     = 3'd5
  } state_t;

  // Shared down-counter preloads: LOAD/DUMP count the remaining strobe
  // cycles after the first, REDIRECT counts the bubbles after the strobe.
  localparam logic [7:0] LOAD_INIT   = 8'(LOAD_CYCLES - 1);
  localparam logic [7:0] DUMP_INIT   = 8'(DUMP_CYCLES - 1);
  localparam logic [7:0] BUBBLE_INIT = 8'(BUBBLE_CYCLES);

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_s;
  logic        s_mxpc_s;
  logic        w_pc_s;
  logic        read_file_s;
  logic        write_file_s;
  logic        we_s;
  logic        fetch_valid_s;
  logic        halted_s;
  logic [15:0] fetch_count_s;
  logic        halt_hit_s;
  logic        unused_instr_s;

  assign halt_hit_s     = (instruction[31:26] == HALT_OPCODE);
  // Only the opcode field matters to the sequencer.
  assign unused_instr_s = ^instruction[25:0];

  // Next-state and next-output decode; everything defaults to idle/zero.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    s_mxpc_s      = 1'b0;
    w_pc_s        = 1'b0;
    read_file_s   = 1'b0;
    write_file_s  = 1'b0;
    we_s          = 1'b0;
    fetch_valid_s = 1'b0;
    halted_s      = 1'b0;
    fetch_count_s = fetch_count;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s       = ST_LOAD;
          cnt_s         = LOAD_INIT;
          read_file_s   = 1'b1;
          fetch_count_s = 16'd0;
        end else begin
          we_s = host_we;
        end
      end
      ST_LOAD: begin
        // Control inputs are deliberately ignored while memory loads.
        if (cnt_r == 8'd0) begin
          state_s       = ST_RUN;
          w_pc_s        = 1'b1;
          fetch_valid_s = 1'b1;
          fetch_count_s = fetch_count + 16'd1;
        end else begin
          read_file_s = 1'b1;
          cnt_s       = cnt_r - 8'd1;
        end
      end
      ST_RUN: begin
        if (branch_req) begin
          // Branch flushes the current word, including a HALT opcode.
          state_s  = ST_REDIRECT;
          cnt_s    = BUBBLE_INIT;
          s_mxpc_s = 1'b1;
          w_pc_s   = 1'b1;
        end else if (stall) begin
          fetch_valid_s = 1'b1;
        end else if (halt_hit_s) begin
          state_s  = ST_HALT;
          halted_s = 1'b1;
        end else begin
          w_pc_s        = 1'b1;
          fetch_valid_s = 1'b1;
          fetch_count_s = fetch_count + 16'd1;
        end
      end
      ST_REDIRECT: begin
        if (branch_req) begin
          cnt_s    = BUBBLE_INIT;
          s_mxpc_s = 1'b1;
          w_pc_s   = 1'b1;
        end else if (cnt_r != 8'd0) begin
          cnt_s = cnt_r - 8'd1;
        end else begin
          state_s       = ST_RUN;
          w_pc_s        = 1'b1;
          fetch_valid_s = 1'b1;
          fetch_count_s = fetch_count + 16'd1;
        end
      end
      ST_HALT: begin
        if (dump_req) begin
          // Dump takes precedence; a coincident start is dropped.
          state_s      = ST_DUMP;
          cnt_s        = DUMP_INIT;
          write_file_s = 1'b1;
        end else if (start) begin
          state_s       = ST_LOAD;
          cnt_s         = LOAD_INIT;
          read_file_s   = 1'b1;
          fetch_count_s = 16'd0;
        end else begin
          halted_s = 1'b1;
          we_s     = host_we;
        end
      end
      ST_DUMP: begin
        if (cnt_r != 8'd0) begin
          write_file_s = 1'b1;
          cnt_s        = cnt_r - 8'd1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      S_MXPC      <= 1'b0;
      W_PC        <= 1'b0;
      read_file   <= 1'b0;
      write_file  <= 1'b0;
      WE          <= 1'b0;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      S_MXPC      <= s_mxpc_s;
      W_PC        <= w_pc_s;
      read_file   <= read_file_s;
      write_file  <= write_file_s;
      WE          <= we_s;
      fetch_valid <= fetch_valid_s;
      halted      <= halted_s;
      fetch_count <= fetch_count_s;
    end
  end

endmodule
